// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment scan path:
//   DEF_N_DIGITS   default number of digits on the shared bus
//   MODE_SCR_UP    mode encoding: scroll toward higher digit index
//   MODE_SCR_DN    mode encoding: scroll toward lower digit index
//   scan_state_t   scan FSM states (blank gap / digit shown)
//   HEX_SEG_TBL    active-low hex glyphs, {dp,g,f,e,d,c,b,a}, dp off
// -----------------------------------------------------------------------------
package seg_pkg;

   localparam int DEF_N_DIGITS = 8;

   localparam logic [1:0] MODE_SCR_UP = 2'b00;
   localparam logic [1:0] MODE_SCR_DN = 2'b10;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } scan_state_t;

   // Entry n is the glyph for nibble n (entry 15 listed first).
   localparam logic [15:0][7:0] HEX_SEG_TBL = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

endpackage

// File: rtl/seg_hex_decode.sv
// -----------------------------------------------------------------------------
// seg_hex_decode
// Combinational nibble to active-low seven-segment glyph decoder.
// Ports:
//   nib    in  4  hex digit value 0..F
//   seg_n  out 8  active-low segments {dp,g,f,e,d,c,b,a}, dp always 1
// -----------------------------------------------------------------------------
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0] nib,
   output logic [7:0] seg_n
);

   assign seg_n = HEX_SEG_TBL[nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Owns the digit buffer and time-multiplexes it onto the shared anode/segment
// bus, one digit per slot, with an all-off gap at the start of every slot so
// the previous digit's segments cannot ghost onto the next anode. At each
// frame boundary (digit index wrapping to 0) it either loads a pending buffer
// offered by game logic or scrolls the buffer according to mode.
//
// Build option:
//   SEG_HEX_DECODE_EN  defined   : seg_n carries the decoded hex glyph
//                      undefined : seg_n = {4'hF, nibble} for an external decoder
//
// Ports:
//   clk         in   1            system clock, rising edge
//   rst_n       in   1            asynchronous active-low reset
//   mode        in   2            00 scroll up, 10 scroll down, x1 hold
//   upd_valid   in   1            new buffer offered
//   upd_data    in   4*N_DIGITS   digit k = upd_data[4k+3:4k]
//   upd_ready   out  1            pending slot free
//   an_n        out  N_DIGITS     active-low anodes, bit k = digit k
//   seg_n       out  8            active-low segments {dp,g,f,e,d,c,b,a}
//   frame_tick  out  1            one-cycle pulse after each frame boundary
// -----------------------------------------------------------------------------
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int N_DIGITS   = DEF_N_DIGITS,
   parameter int SCAN_DIV   = 50000,
   parameter int BLANK_CYC  = 16,
   parameter int ROT_FRAMES = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [1:0]              mode,
   input  logic                    upd_valid,
   input  logic [4*N_DIGITS-1:0]   upd_data,
   output logic                    upd_ready,
   output logic [N_DIGITS-1:0]     an_n,
   output logic [7:0]              seg_n,
   output logic                    frame_tick
);

   localparam int IDX_W = (N_DIGITS > 1)   ? $clog2(N_DIGITS)   : 1;
   localparam int CNT_W = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
   localparam int ROT_W = (ROT_FRAMES > 1) ? $clog2(ROT_FRAMES) : 1;

   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - BLANK_CYC - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);
   localparam logic [ROT_W-1:0] ROT_LAST   = ROT_W'(ROT_FRAMES - 1);

   scan_state_t state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [IDX_W-1:0]  idx_q;
   logic [ROT_W-1:0]  rot_q;
   logic [3:0]        dbuf_q [N_DIGITS];
   logic [4*N_DIGITS-1:0] pend_q;
   logic              pend_full_q;

   logic blank_end, slot_end, boundary, transfer;
   logic [3:0] cur_nib;
   logic [7:0] glyph;
   logic [N_DIGITS-1:0] an_d;
   logic [7:0] seg_d;
   logic [N_DIGITS-1:0] an_n_p1;
   logic [7:0]          seg_n_p1;
   logic                tick_p1;

   assign blank_end = (state_q == ST_BLANK) && (cnt_q == BLANK_LAST);
   assign slot_end  = (state_q == ST_SHOW)  && (cnt_q == SHOW_LAST);
   assign boundary  = slot_end && (idx_q == IDX_LAST);
   assign upd_ready = ~pend_full_q;
   assign transfer  = upd_valid && ~pend_full_q;

   // ---- p0: scan FSM, slot counter and digit index ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_BLANK;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_BLANK: if (blank_end) state_d = ST_SHOW;
         ST_SHOW:  if (slot_end)  state_d = ST_BLANK;
         default:  state_d = ST_BLANK;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         idx_q <= '0;
      end else begin
         // Counter runs per state phase, restarting at each phase change.
         if (blank_end || slot_end) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         if (slot_end) begin
            idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
         end
      end
   end

   // Pending data holds no control meaning on its own, so it is not reset.
   always_ff @(posedge clk) begin
      if (transfer) begin
         pend_q <= upd_data;
      end
   end

   // Buffer, pending flag and scroll counter; loading a pending buffer wins
   // over scrolling, and mode is only looked at on the boundary cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N_DIGITS; k++) begin
            dbuf_q[k] <= 4'(k + 1);
         end
         pend_full_q <= 1'b0;
         rot_q       <= '0;
      end else begin
         if (transfer) begin
            pend_full_q <= 1'b1;
         end
         if (boundary) begin
            if (pend_full_q) begin
               for (int k = 0; k < N_DIGITS; k++) begin
                  dbuf_q[k] <= pend_q[4*k +: 4];
               end
               pend_full_q <= 1'b0;
               rot_q       <= '0;
            end else if (mode == MODE_SCR_UP) begin
               if (rot_q == ROT_LAST) begin
                  dbuf_q[0] <= dbuf_q[N_DIGITS-1];
                  for (int k = 1; k < N_DIGITS; k++) begin
                     dbuf_q[k] <= dbuf_q[k-1];
                  end
                  rot_q <= '0;
               end else begin
                  rot_q <= rot_q + ROT_W'(1);
               end
            end else if (mode == MODE_SCR_DN) begin
               if (rot_q == ROT_LAST) begin
                  dbuf_q[N_DIGITS-1] <= dbuf_q[0];
                  for (int k = 0; k < N_DIGITS-1; k++) begin
                     dbuf_q[k] <= dbuf_q[k+1];
                  end
                  rot_q <= '0;
               end else begin
                  rot_q <= rot_q + ROT_W'(1);
               end
            end
         end
      end
   end

   assign cur_nib = dbuf_q[idx_q];

`ifdef SEG_HEX_DECODE_EN
   seg_hex_decode u_dec (
      .nib   (cur_nib),
      .seg_n (glyph)
   );
`else
   assign glyph = {4'hF, cur_nib};
`endif

   always_comb begin
      an_d  = '1;
      seg_d = 8'hFF;
      if (state_q == ST_SHOW) begin
         an_d[idx_q] = 1'b0;
         seg_d       = glyph;
      end
   end

   // ---- p1: registered bus drive and frame pulse ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_n_p1  <= '1;
         seg_n_p1 <= 8'hFF;
         tick_p1  <= 1'b0;
      end else begin
         an_n_p1  <= an_d;
         seg_n_p1 <= seg_d;
         tick_p1  <= boundary;
      end
   end

   assign an_n       = an_n_p1;
   assign seg_n      = seg_n_p1;
   assign frame_tick = tick_p1;

endmodule
